axis_pkt_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one downstream AXI-Stream image pipeline, such as the pipelined register stage, between two AXI-Stream sources. A grant is held for a whole packet, from first beat through the beat carrying `last`, so pixel lines from different sources never interleave. The output is registered through a skid buffer, so the block sustains one beat per cycle inside a packet and adds one bubble cycle per arbitration.

---
 rtl/axis_arb_pkg.sv | 35 +++
 rtl/axis_skid_buf.sv | 67 ++++++
 rtl/axis_pkt_arbiter.sv | 136 +++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : axis_arb_pkg                                               |
// | Purpose : Shared types and helpers for the AXI-Stream packet arbiter |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+

// Fallback beat width when the image VIP does not provide one.
`ifndef AXIS_IMAGE_VIP_SOURCE_BYTES
`define AXIS_IMAGE_VIP_SOURCE_BYTES 1
`endif

package axis_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // One-hot owner vector for a given arbiter state; 2'b00 when idle.
  function automatic logic [1:0] grant_onehot(input arb_state_t s);
    logic [1:0] g;
    g = 2'b00;
    case (s)
      GNT0:    g = 2'b01;
      GNT1:    g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : axis_skid_buf                                              |
// | Purpose : Two-entry registered output stage (output reg + one skid   |
// |           entry). in_ready_o comes straight from a flop, so there is |
// |           no combinational path from out_ready_i back upstream.      |
// | Ports   : clk_i, rst_i          clock, sync active-high reset        |
// |           in_data/valid/ready  upstream handshake                    |
// |           out_data/valid/ready downstream handshake                  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module axis_skid_buf #(
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             out_valid_q;
  logic             skid_full_q;
  logic             in_fire;
  logic             out_load;

  assign in_ready_o  = !skid_full_q;
  assign in_fire     = in_valid_i && !skid_full_q;
  // Output register may take a new beat when empty or being drained.
  assign out_load    = !out_valid_q || out_ready_i;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_data_q  <= '0;
      skid_data_q <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (out_load) begin
      // Skid entry is older than anything on the input, so it goes first.
      // While it is full the input is not ready, so nothing is lost.
      if (skid_full_q) begin
        out_data_q  <= skid_data_q;
        out_valid_q <= 1'b1;
        skid_full_q <= 1'b0;
      end else begin
        out_valid_q <= in_fire;
        if (in_fire) begin
          out_data_q <= in_data_i;
        end
      end
    end else if (in_fire) begin
      // Output is stalled: park the beat accepted this cycle.
      skid_data_q <= in_data_i;
      skid_full_q <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : axis_pkt_arbiter                                           |
// | Purpose : Packet-level round-robin arbiter sharing one AXI-Stream    |
// |           sink between two sources. A grant is held from first beat |
// |           to the beat with last; a watchdog cuts runaway packets.   |
// | Ports   : clk_i, rst_i                 clock, sync active-high reset |
// |           axis_s0_* / axis_s1_*        source streams                |
// |           axis_m_*                     shared sink stream            |
// |           grant_o                      one-hot owner, 00 when idle   |
// |           wdog_err_o                   sticky packet-length error    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`ifndef AXIS_IMAGE_VIP_SOURCE_BYTES
`define AXIS_IMAGE_VIP_SOURCE_BYTES 1
`endif

module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_BYTES = `AXIS_IMAGE_VIP_SOURCE_BYTES,
  parameter int DATA_BITS  = DATA_BYTES * 8,
  parameter int MAX_BEATS  = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] axis_s0_data_i,
  input  logic                 axis_s0_valid_i,
  output logic                 axis_s0_ready_o,
  input  logic                 axis_s0_last_i,
  input  logic [DATA_BITS-1:0] axis_s1_data_i,
  input  logic                 axis_s1_valid_i,
  output logic                 axis_s1_ready_o,
  input  logic                 axis_s1_last_i,
  output logic [DATA_BITS-1:0] axis_m_data_o,
  output logic                 axis_m_valid_o,
  input  logic                 axis_m_ready_i,
  output logic                 axis_m_last_o,
  output logic [1:0]           grant_o,
  output logic                 wdog_err_o
);

  localparam int BCNT_W = $clog2(MAX_BEATS);
  localparam logic [BCNT_W-1:0] C_BCNT_MAX = BCNT_W'(MAX_BEATS - 1);

  arb_state_t          state_q;
  logic                rr_q;
  logic                wdog_q;
  logic [BCNT_W-1:0]   bcnt_q;

  logic                skid_rdy;
  logic                sel_valid;
  logic                sel_last;
  logic [DATA_BITS-1:0] sel_data;
  logic                accept;
  logic                wdog_hit;
  logic                out_last;

  // Input mux: only the granted source reaches the output stage.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = axis_s0_data_i;
    sel_last  = axis_s0_last_i;
    case (state_q)
      GNT0: sel_valid = axis_s0_valid_i;
      GNT1: begin
        sel_valid = axis_s1_valid_i;
        sel_data  = axis_s1_data_i;
        sel_last  = axis_s1_last_i;
      end
      default: sel_valid = 1'b0;
    endcase
  end

  assign accept   = sel_valid && skid_rdy;
  // Beat number MAX_BEATS without last: terminate the packet here.
  assign wdog_hit = accept && !sel_last && (bcnt_q == C_BCNT_MAX);
  assign out_last = sel_last || wdog_hit;

  assign axis_s0_ready_o = (state_q == GNT0) && skid_rdy;
  assign axis_s1_ready_o = (state_q == GNT1) && skid_rdy;
  assign grant_o         = grant_onehot(state_q);
  assign wdog_err_o      = wdog_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      bcnt_q  <= '0;
      wdog_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // rr names the source that wins a tie; each grant hands it over.
          if (axis_s0_valid_i && (!axis_s1_valid_i || !rr_q)) begin
            state_q <= GNT0;
            rr_q    <= 1'b1;
            bcnt_q  <= '0;
          end else if (axis_s1_valid_i) begin
            state_q <= GNT1;
            rr_q    <= 1'b0;
            bcnt_q  <= '0;
          end
        end
        GNT0, GNT1: begin
          if (accept) begin
            bcnt_q <= bcnt_q + 1'b1;
            if (out_last) begin
              state_q <= IDLE;
            end
            if (wdog_hit) begin
              wdog_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_skid_buf #(
    .WIDTH (DATA_BITS + 1)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   ({out_last, sel_data}),
    .in_valid_i  (sel_valid),
    .in_ready_o  (skid_rdy),
    .out_data_o  ({axis_m_last_o, axis_m_data_o}),
    .out_valid_o (axis_m_valid_o),
    .out_ready_i (axis_m_ready_i)
  );

endmodule

`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_axis_pkt_arbiter                                        |
// | Purpose : Self-checking bench for axis_pkt_arbiter. Sources replay   |
// |           beat queues; expected output is built packet by packet    |
// |           from the round-robin and watchdog rules.                  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_axis_pkt_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s0_data, s1_data, m_data;
  logic       s0_valid, s0_ready, s0_last;
  logic       s1_valid, s1_ready, s1_last;
  logic       m_valid, m_ready, m_last;
  logic [1:0] grant;
  logic       wdog;

  always #5 clk = ~clk;

  axis_pkt_arbiter #(
    .DATA_BYTES (1),
    .MAX_BEATS  (MAXB)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .axis_s0_data_i  (s0_data),
    .axis_s0_valid_i (s0_valid),
    .axis_s0_ready_o (s0_ready),
    .axis_s0_last_i  (s0_last),
    .axis_s1_data_i  (s1_data),
    .axis_s1_valid_i (s1_valid),
    .axis_s1_ready_o (s1_ready),
    .axis_s1_last_i  (s1_last),
    .axis_m_data_o   (m_data),
    .axis_m_valid_o  (m_valid),
    .axis_m_ready_i  (m_ready),
    .axis_m_last_o   (m_last),
    .grant_o         (grant),
    .wdog_err_o      (wdog)
  );

  typedef struct packed { logic [7:0] d; logic l; } beat_t;
  typedef struct packed { logic [7:0] d; logic l; logic first; } exp_t;

  beat_t q0[$], q1[$];        // beats still to be offered by each source
  beat_t stg0[$], stg1[$];    // staging for the next phase
  exp_t  exp_q[$];            // expected output stream
  logic  pat_q[$];            // explicit sink-ready pattern
  bit    rnd_ready = 1'b0;
  bit    gap_chk   = 1'b0;
  bit    model_rr  = 1'b0;
  bit    model_wdog = 1'b0;
  int    last_stamp = -1;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  logic [7:0] dseq = 8'h10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    if (s == 0) stg0.push_back(b); else stg1.push_back(b);
  endtask

  task automatic gen(input int s, input int npk);
    for (int p = 0; p < npk; p++) begin
      int len;
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++) begin
        push(s, dseq, i == len - 1);
        dseq = dseq + 8'd1;
      end
    end
  endtask

  // Hand the staged beats to the sources and predict the output: whole
  // packets, ties broken by rr, any packet cut after MAXB beats.
  task automatic load_phase(input bit with_gap);
    int    idx0, idx1, g, cnt;
    beat_t b;
    exp_t  e;
    idx0 = 0;
    idx1 = 0;
    gap_chk    = with_gap;
    last_stamp = -1;
    foreach (stg0[i]) q0.push_back(stg0[i]);
    foreach (stg1[i]) q1.push_back(stg1[i]);
    while (idx0 < stg0.size() || idx1 < stg1.size()) begin
      if (idx0 < stg0.size() && idx1 < stg1.size()) g = model_rr ? 1 : 0;
      else g = (idx0 < stg0.size()) ? 0 : 1;
      model_rr = (g == 0);
      cnt = 0;
      e.l = 1'b0;
      while (!e.l) begin
        if (g == 0) begin b = stg0[idx0]; idx0++; end
        else        begin b = stg1[idx1]; idx1++; end
        cnt++;
        e.d     = b.d;
        e.first = (cnt == 1);
        if (b.l) e.l = 1'b1;
        else if (cnt == MAXB) begin e.l = 1'b1; model_wdog = 1'b1; end
        else e.l = 1'b0;
        exp_q.push_back(e);
      end
    end
    stg0.delete();
    stg1.delete();
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_time", k < 400, 1);
    repeat (3) @(negedge clk);
    chk("idle_valid", m_valid, 0);
    chk("idle_grant", grant, 0);
    chk("wdog_state", wdog, model_wdog);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete(); exp_q.delete(); pat_q.delete();
    model_rr   = 1'b0;
    model_wdog = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Source/sink driver and stream monitor. Samples 2 time units before the
  // rising edge, updates 1 time unit after it.
  initial begin
    bit         f0, f1, fm, pst, pfire, prst, stall, infire;
    logic [7:0] pd, cd;
    logic       pl, cl;
    exp_t       e;
    s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0;
    s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0;
    m_ready  = 1'b1;
    pst = 1'b0; pfire = 1'b0; prst = 1'b1; pd = '0; pl = 1'b0;
    forever begin
      @(negedge clk); #3;
      stall  = m_valid && !m_ready;
      infire = (s0_valid && s0_ready) || (s1_valid && s1_ready);
      if (pst && !prst) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
        chk("hold_last", m_last, pl);
        if (pfire && stall) chk("ready_drop", {s0_ready, s1_ready}, 0);
      end
      f0 = !rst && s0_valid && s0_ready;
      f1 = !rst && s1_valid && s1_ready;
      fm = !rst && m_valid && m_ready;
      cd = m_data;
      cl = m_last;
      pst = stall; pfire = infire; prst = rst; pd = m_data; pl = m_last;

      @(posedge clk); #1;
      cyc++;
      if (f0 && q0.size() != 0) void'(q0.pop_front());
      if (f1 && q1.size() != 0) void'(q1.pop_front());
      if (fm) begin
        chk("beat_was_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", cd, e.d);
          chk("out_last", cl, e.l);
          if (gap_chk && last_stamp >= 0) chk("beat_gap", cyc - last_stamp, e.first ? 2 : 1);
          last_stamp = cyc;
        end
      end
      s0_valid = q0.size() != 0;
      if (s0_valid) {s0_data, s0_last} = q0[0]; else {s0_data, s0_last} = '0;
      s1_valid = q1.size() != 0;
      if (s1_valid) {s1_data, s1_last} = q1[0]; else {s1_data, s1_last} = '0;
      if (pat_q.size() != 0) m_ready = pat_q.pop_front();
      else if (rnd_ready)    m_ready = ($urandom_range(3, 0) != 0);
      else                   m_ready = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_grant", grant, 0);
    chk("rst_wdog", wdog, 0);
    chk("rst_readies", {s0_ready, s1_ready}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single source, 3-beat packet, cycle-exact
    push(0, 8'hA1, 0); push(0, 8'hA2, 0); push(0, 8'hA3, 1);
    load_phase(1);
    @(negedge clk);
    chk("t1_grant_idle", grant, 2'b00);
    chk("t1_valid_idle", m_valid, 0);
    @(negedge clk);
    chk("t1_grant", grant, 2'b01);
    chk("t1_rdy", {s0_ready, s1_ready}, 2'b10);
    @(negedge clk);
    chk("t1_b1", {m_valid, m_last, m_data}, {2'b10, 8'hA1});
    chk("t1_grant_b1", grant, 2'b01);
    @(negedge clk);
    chk("t1_b2", {m_valid, m_last, m_data}, {2'b10, 8'hA2});
    @(negedge clk);
    chk("t1_b3", {m_valid, m_last, m_data}, {2'b11, 8'hA3});
    chk("t1_grant_end", grant, 2'b00);
    @(negedge clk);
    chk("t1_after", m_valid, 0);
    wait_drain();

    // Tie: both sources hold two 2-beat packets
    do_reset();
    push(0, 8'h01, 0); push(0, 8'h02, 1); push(0, 8'h03, 0); push(0, 8'h04, 1);
    push(1, 8'h11, 0); push(1, 8'h12, 1); push(1, 8'h13, 0); push(1, 8'h14, 1);
    load_phase(1);
    wait_drain();

    // Backpressure on an 8-beat s1 packet (cut at MAXB by the watchdog)
    for (int i = 0; i < 8; i++) push(1, 8'h40 + 8'(i), i == 7);
    pat_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    load_phase(0);
    wait_drain();

    // Watchdog: 6 beats from s0, last only on beat 6
    do_reset();
    chk("wd_pre", wdog, 0);
    for (int i = 0; i < 6; i++) push(0, 8'h60 + 8'(i), i == 5);
    load_phase(1);
    wait_drain();
    chk("wd_set", wdog, 1);

    // Reset during beat 2 of 5, then a tie must go to s0
    for (int i = 0; i < 5; i++) push(0, 8'h70 + 8'(i), i == 4);
    load_phase(0);
    repeat (3) @(negedge clk);
    chk("mr_pre_b1", {m_valid, m_data}, {1'b1, 8'h70});
    rst = 1'b1;
    q0.delete(); q1.delete(); exp_q.delete();
    model_rr = 1'b0; model_wdog = 1'b0;
    @(negedge clk);
    chk("mr_valid", m_valid, 0);
    chk("mr_last", m_last, 0);
    chk("mr_data", m_data, 0);
    chk("mr_grant", grant, 0);
    chk("mr_wdog", wdog, 0);
    chk("mr_readies", {s0_ready, s1_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    push(0, 8'h81, 0); push(0, 8'h82, 1);
    push(1, 8'h91, 0); push(1, 8'h92, 1);
    load_phase(1);
    repeat (3) @(negedge clk);
    chk("mr_tie_s0_first", {m_valid, m_data}, {1'b1, 8'h81});
    wait_drain();

    // Randomized phases
    for (int ph = 0; ph < 16; ph++) begin
      int n0, n1;
      n0 = $urandom_range(3, 0);
      n1 = $urandom_range(3, 0);
      if (n0 + n1 == 0) n0 = 1;
      gen(0, n0);
      gen(1, n1);
      rnd_ready = ($urandom_range(1, 0) == 1);
      load_phase(!rnd_ready);
      wait_drain();
      rnd_ready = 1'b0;
      if (ph == 7) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
